button_debounce_capture: RTL and testbench
==========================================

// Module: button_debounce_capture
// PURPOSE
//  Conditions the raw active-low on-board push buttons before they reach the okWireOut status endpoint.
//  Each button is synchronised to ti_clk, debounced, and delivered as a stable active-high level.
//  Release-to-press transitions are latched as sticky event flags, which host software clears through a Wire In.
//  Output status_word drives the 16-bit okWireOut datain directly.
// PARAMETERS
//  N_BTN            4       number of buttons, legal range 1..4
//  DEBOUNCE_CYCLES  50000   consecutive ti_clk cycles a new level must persist before acceptance, >=2
// PORTS
//  ti_clk        in   1      host interface clock; every register in the block uses it
//  reset         in   1      asynchronous, active-high reset
//  button        in   N_BTN  raw pins, active-low, asynchronous to ti_clk
//  event_clear   in   N_BTN  one-cycle pulse per bit; clears the matching btn_event bit
//  count_clear   in   1      one-cycle pulse; clears press_total (only used when the macro is defined)
//  btn_level     out  N_BTN  debounced level, 1 = pressed
//  btn_event     out  N_BTN  sticky press flag per button
//  press_pulse   out  N_BTN  one-cycle strobe on each accepted press
//  irq           out  1      registered OR-reduction of btn_event
//  status_word   out  16     {press_total[7:0], ev[3:0], lvl[3:0]}; unused bits are zero
// BEHAVIOUR
//  Reset values:
//   - sync stages = all 1s (released)
//   - debounce counters = 0
//   - btn_level, btn_event, press_pulse, irq = 0
//   - press_total = 0
//  Reset is asynchronous assert and synchronous release. Asserting reset mid-debounce discards the partial count.
//  Synchroniser: two flops per bit. s = ~sync2, so s is active-high.
//  Debounce, per bit, on every edge:
//   - s == lvl: cnt <= 0.
//   - s != lvl and cnt == DEBOUNCE_CYCLES-1: lvl <= s, cnt <= 0.
//   - s != lvl otherwise: cnt <= cnt+1.
//   - Counter width is $clog2(DEBOUNCE_CYCLES). It never wraps.
//  Latency: a clean pin step changes btn_level exactly 2+DEBOUNCE_CYCLES edges after the first capturing edge.
//  Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES synced cycles leaves btn_level unchanged and resets cnt.
//  Press event (lvl 0->1):
//   - press_pulse is high for exactly the one cycle in which btn_level first reads 1.
//   - btn_event sets on the same edge.
//  Release (lvl 1->0) produces no event.
//  Clearing: event_clear[i] clears btn_event[i] on the next edge.
//   - If set and clear coincide for the same bit, set wins and the event is kept.
//  irq follows btn_event with one cycle of latency.
//  status_word is combinational from registered state, so it carries no extra latency.
//  Bits for buttons at index >= N_BTN read 0.
// CONFIGURATION
//  Macro BTN_PRESS_COUNT_EN.
//  When defined:
//   - press_total is an 8-bit counter that increments by popcount(press_pulse) each cycle.
//   - press_total saturates at 8'hFF and never wraps.
//   - count_clear zeroes it. If count_clear coincides with presses, the result is popcount(press_pulse).
//  When undefined:
//   - No counter logic is built.
//   - status_word[15:8] is tied to 8'h00.
//   - count_clear is ignored.
// TESTING (DEBOUNCE_CYCLES=4, N_BTN=4, run both with and without the macro)
//  1. Release reset with button=4'hF and hold 20 cycles -> all outputs 0; status_word=16'h0000.
//  2. Drive button[0]=0 and hold:
//     - btn_level[0]=1 exactly 6 edges after capture.
//     - press_pulse[0] high for 1 cycle.
//     - status_word=16'h0011.
//     - irq=1 one cycle later.
//  3. Low glitch of 3 cycles on button[1] -> btn_level and btn_event unchanged; no press_pulse.
//  4. Pulse event_clear[0] on the same edge that btn_event[0] sets from a second press -> btn_event[0] stays 1.
//     Pulse event_clear[0] again -> btn_event[0]=0 and irq=0 one cycle later.
//  5. Assert reset mid-debounce (cnt=2), release, keep the button pressed -> the full 6-edge latency repeats from scratch.
//  6. Macro defined: 300 single-button presses -> press_total=8'hFF, saturated.
//     Then count_clear -> 8'h00.

Source files
------------

// File: rtl/button_debounce_capture_if.sv
// Status bundle between the push-button conditioner and the okWireOut/WireIn host side.
// The conditioner uses the slave modport; the host side uses the master modport.
`default_nettype none
`timescale 1ns/1ps

interface button_debounce_capture_if #(
   parameter int N_BTN = 4
) ();
   logic [N_BTN-1:0] button;
   logic [N_BTN-1:0] event_clear;
   logic             count_clear;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_event;
   logic [N_BTN-1:0] press_pulse;
   logic             irq;
   logic [15:0]      status_word;

   modport slave (
      input  button, event_clear, count_clear,
      output btn_level, btn_event, press_pulse, irq, status_word
   );

   modport master (
      output button, event_clear, count_clear,
      input  btn_level, btn_event, press_pulse, irq, status_word
   );
endinterface

`default_nettype wire

// File: rtl/button_debounce_capture.sv
// =====================================================================
// button_debounce_capture: sync, debounce and sticky press capture for
// active-low buttons. Optional macro BTN_PRESS_COUNT_EN adds press_total.
// Revision: 1.0
// =====================================================================
`default_nettype none
`timescale 1ns/1ps

module button_debounce_capture #(
   parameter int N_BTN           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                    ti_clk,
   input  logic                    reset,
   button_debounce_capture_if.slave bus
);
   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_BTN-1:0] sync1_q, sync2_q;
   logic [N_BTN-1:0] s;
   logic [N_BTN-1:0] lvl_q, lvl_d;
   logic [N_BTN-1:0] pulse_q, pulse_d;
   logic [N_BTN-1:0] ev_q, ev_d;
   logic             irq_q;
   logic [7:0]       press_total;

   assign s = ~sync2_q;

   for (genvar i = 0; i < N_BTN; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;

      assign lvl_d[i] = (s[i] != lvl_q[i] && cnt_q == CNT_MAX) ? s[i] : lvl_q[i];

      always_comb begin
         cnt_d = '0;
         if (s[i] != lvl_q[i] && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge ti_clk or posedge reset) begin
         if (reset) cnt_q <= '0;
         else       cnt_q <= cnt_d;
      end
   end

   // Set has priority over a coincident host clear so no press is lost.
   assign pulse_d = lvl_d & ~lvl_q;
   assign ev_d    = (ev_q & ~bus.event_clear) | pulse_d;

   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '1;
         sync2_q <= '1;
         lvl_q   <= '0;
         pulse_q <= '0;
         ev_q    <= '0;
         irq_q   <= 1'b0;
      end else begin
         sync1_q <= bus.button;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         pulse_q <= pulse_d;
         ev_q    <= ev_d;
         irq_q   <= |ev_q;
      end
   end

`ifdef BTN_PRESS_COUNT_EN
   logic [7:0] total_q, total_d;
   logic [3:0] pop;
   logic [8:0] sum;

   always_comb begin
      pop = '0;
      for (int i = 0; i < N_BTN; i++)
         pop = pop + 4'(pulse_q[i]);
      sum = {1'b0, total_q} + 9'(pop);
      if (bus.count_clear) total_d = 8'(pop);
      else if (sum[8])     total_d = 8'hFF;
      else                 total_d = sum[7:0];
   end

   always_ff @(posedge ti_clk or posedge reset) begin
      if (reset) total_q <= '0;
      else       total_q <= total_d;
   end

   assign press_total = total_q;
`else
   logic unused_count_clear;
   assign unused_count_clear = bus.count_clear;
   assign press_total        = 8'h00;
`endif

   assign bus.btn_level   = lvl_q;
   assign bus.btn_event   = ev_q;
   assign bus.press_pulse = pulse_q;
   assign bus.irq         = irq_q;
   assign bus.status_word = {press_total, 4'(ev_q), 4'(lvl_q)};

endmodule

`default_nettype wire

// File: tb/tb_button_debounce_capture.sv
// Self-checking bench for button_debounce_capture: directed scenarios plus
// randomized pin activity against a cycle-level reference model.
`default_nettype none
`timescale 1ns/1ps

module tb_button_debounce_capture;
   localparam int N_BTN = 4;
   localparam int DEB   = 4;

   logic ti_clk = 1'b0;
   logic reset;

   button_debounce_capture_if #(.N_BTN(N_BTN)) bus ();

   button_debounce_capture #(
      .N_BTN(N_BTN),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .ti_clk(ti_clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 ti_clk = ~ti_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pressed state seen one and two edges back, and the
   // length of the current run of synced samples disagreeing with the level.
   logic [N_BTN-1:0] m_d1, m_d2;
   int               m_run [N_BTN];
   logic [N_BTN-1:0] m_lvl, m_ev, m_pulse;
   logic             m_irq;
   int               m_total;

   always @(posedge ti_clk or posedge reset) begin
      logic [N_BTN-1:0] rise;
      logic             irq_n;
      if (reset) begin
         m_d1 = '0; m_d2 = '0;
         for (int i = 0; i < N_BTN; i++) m_run[i] = 0;
         m_lvl = '0; m_ev = '0; m_pulse = '0; m_irq = 1'b0; m_total = 0;
      end else begin
         irq_n = |m_ev;
`ifdef BTN_PRESS_COUNT_EN
         if (bus.count_clear) m_total = $countones(m_pulse);
         else if (m_total + $countones(m_pulse) > 255) m_total = 255;
         else m_total = m_total + $countones(m_pulse);
`endif
         rise = '0;
         for (int i = 0; i < N_BTN; i++) begin
            if (m_d2[i] != m_lvl[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == DEB) begin
                  m_lvl[i] = m_d2[i];
                  m_run[i] = 0;
                  rise[i]  = m_d2[i];
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_ev    = (m_ev & ~bus.event_clear) | rise;
         m_pulse = rise;
         m_irq   = irq_n;
         m_d2    = m_d1;
         m_d1    = ~bus.button;
      end
   end

   function automatic logic [15:0] model_status();
      logic [7:0] hi;
`ifdef BTN_PRESS_COUNT_EN
      hi = 8'(m_total);
`else
      hi = 8'h00;
`endif
      return {hi, 4'(m_ev), 4'(m_lvl)};
   endfunction

   always @(negedge ti_clk) begin
      if (!reset) begin
         check("cmp_level", 16'(bus.btn_level),   16'(m_lvl));
         check("cmp_event", 16'(bus.btn_event),   16'(m_ev));
         check("cmp_pulse", 16'(bus.press_pulse), 16'(m_pulse));
         check("cmp_irq",   16'(bus.irq),         16'(m_irq));
         check("cmp_status", bus.status_word,     model_status());
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge ti_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.button = '1;
      bus.event_clear = '0;
      bus.count_clear = 1'b0;
      tick(3);
      reset = 1'b0;

      // Idle after reset
      tick(20);
      check("t1_status", bus.status_word, 16'h0000);
      check("t1_irq", 16'(bus.irq), 16'h0);
      check("t1_pulse", 16'(bus.press_pulse), 16'h0);

      // Clean press on button 0: accepted on the 6th edge counting the capture edge
      bus.button[0] = 1'b0;
      tick(5);
      check("t2_level_early", 16'(bus.btn_level[0]), 16'h0);
      tick(1);
      check("t2_level", 16'(bus.btn_level[0]), 16'h1);
      check("t2_pulse", 16'(bus.press_pulse), 16'h1);
      check("t2_status", bus.status_word, 16'h0011);
      check("t2_irq_lag", 16'(bus.irq), 16'h0);
      tick(1);
      check("t2_pulse_end", 16'(bus.press_pulse), 16'h0);
      check("t2_irq", 16'(bus.irq), 16'h1);
`ifdef BTN_PRESS_COUNT_EN
      check("t2_total", bus.status_word, 16'h0111);
`else
      check("t2_total", bus.status_word, 16'h0011);
`endif

      // Three-cycle glitch on button 1 is rejected
      bus.button[1] = 1'b0;
      tick(3);
      bus.button[1] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         check("t3_level", 16'(bus.btn_level[1]), 16'h0);
         check("t3_event", 16'(bus.btn_event[1]), 16'h0);
         check("t3_pulse", 16'(bus.press_pulse[1]), 16'h0);
      end

      // Release, clear, then clear coinciding with a new set
      bus.button[0] = 1'b1;
      tick(8);
      check("t4_released", 16'(bus.btn_level[0]), 16'h0);
      check("t4_still_set", 16'(bus.btn_event[0]), 16'h1);
      bus.event_clear[0] = 1'b1;
      tick(1);
      bus.event_clear[0] = 1'b0;
      check("t4_cleared", 16'(bus.btn_event[0]), 16'h0);
      tick(2);
      bus.button[0] = 1'b0;
      tick(5);
      bus.event_clear[0] = 1'b1;
      tick(1);
      bus.event_clear[0] = 1'b0;
      check("t4_set_wins", 16'(bus.btn_event[0]), 16'h1);
      tick(1);
      bus.event_clear[0] = 1'b1;
      tick(1);
      bus.event_clear[0] = 1'b0;
      check("t4_clear2", 16'(bus.btn_event[0]), 16'h0);
      check("t4_irq_hold", 16'(bus.irq), 16'h1);
      tick(1);
      check("t4_irq_low", 16'(bus.irq), 16'h0);

      // Reset mid-debounce restarts the full latency
      bus.button[0] = 1'b1;
      tick(8);
      bus.button[0] = 1'b0;
      tick(4);
      reset = 1'b1;
      #1;
      check("t5_async_reset", bus.status_word, 16'h0000);
      tick(1);
      reset = 1'b0;
      tick(5);
      check("t5_level_early", 16'(bus.btn_level[0]), 16'h0);
      tick(1);
      check("t5_level", 16'(bus.btn_level[0]), 16'h1);
      bus.button[0] = 1'b1;
      tick(8);

`ifdef BTN_PRESS_COUNT_EN
      // Saturation of the press counter, then clear
      for (int k = 0; k < 300; k++) begin
         bus.button[0] = 1'b0;
         tick(7);
         bus.button[0] = 1'b1;
         tick(7);
      end
      tick(2);
      check("t6_saturated", 16'(bus.status_word[15:8]), 16'h00FF);
      bus.count_clear = 1'b1;
      tick(1);
      bus.count_clear = 1'b0;
      check("t6_cleared", 16'(bus.status_word[15:8]), 16'h0000);
`else
      // count_clear has no effect and the upper byte stays zero
      for (int k = 0; k < 3; k++) begin
         bus.button[2] = 1'b0;
         tick(7);
         bus.count_clear = 1'b1;
         bus.button[2] = 1'b1;
         tick(1);
         bus.count_clear = 1'b0;
         tick(6);
      end
      check("t6_upper_zero", 16'(bus.status_word[15:8]), 16'h0000);
`endif

      // Randomized pin activity with host clears
      for (int k = 0; k < 400; k++) begin
         bus.button      = 4'($urandom);
         bus.event_clear = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         bus.count_clear = ($urandom_range(0, 15) == 0);
         tick(1);
         bus.event_clear = '0;
         bus.count_clear = 1'b0;
         tick($urandom_range(0, 8));
      end
      tick(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
